// File: rtl/fifo_rd_ptr_empty_pkg.sv
// Shared constants and Gray-code helpers for the asynchronous FIFO pointer blocks.
package fifo_rd_ptr_empty_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;
    localparam int PTR_WIDTH      = ADDR_WIDTH_DEF + 1;

    function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ptr_empty_gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain pointer and status controller of the async FIFO: read pointers,
// RAM read address and registered empty / almost-empty / fill-level flags.
module fifo_rd_ptr_empty
    import fifo_rd_ptr_empty_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH:0]   i_wptr_sync,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [ADDR_WIDTH:0]   o_rptr_gray,
    output logic                  o_empty,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_rd_count,
    output logic                  o_rd_ack,
    output logic                  o_underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] count_q, count_d;
    logic [PW-1:0] wbin;
    logic          empty_q, empty_d;
    logic          aempty_q, aempty_d;
    logic          ack_q, ack_d;
    logic          uflow_q, uflow_d;
    logic          rinc;

    gray_to_bin #(.W(PW)) u_wptr_g2b (
        .i_gray (i_wptr_sync),
        .o_bin  (wbin)
    );

    // Flags are derived from the next pointer so they move on the same edge as it.
    always_comb begin
        rinc     = i_rd_en & ~empty_q;
        rbin_d   = rbin_q + PW'(rinc);
        rgray_d  = (rbin_d >> 1) ^ rbin_d;
        empty_d  = (rgray_d == i_wptr_sync);
        count_d  = wbin - rbin_d;
        aempty_d = (count_d <= PW'(ALMOST_EMPTY_TH));
        ack_d    = rinc;
        uflow_d  = i_rd_en & empty_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ack_q    <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ack_q    <= ack_d;
            uflow_q  <= uflow_d;
        end
    end

    assign o_rd_addr      = rbin_q[ADDR_WIDTH-1:0];
    assign o_rptr_gray    = rgray_q;
    assign o_empty        = empty_q;
    assign o_almost_empty = aempty_q;
    assign o_rd_count     = count_q;
    assign o_rd_ack       = ack_q;
    assign o_underflow    = uflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Scoreboard bench for the FIFO read-side pointer / empty controller (ADDR_WIDTH=4, threshold 2).
module tb_fifo_rd_ptr_empty;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en = 1'b0;
    logic [4:0] wptr = '0;
    logic [3:0] rd_addr;
    logic [4:0] rptr_gray;
    logic       empty, aempty, rd_ack, uflow;
    logic [4:0] rd_count;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] addr;
        logic [4:0] gray;
        logic       empty;
        logic       aempty;
        logic [4:0] count;
        logic       ack;
        logic       uf;
    } exp_t;

    exp_t sb_q[$];
    logic [4:0] m_rbin;
    logic       m_empty;

    fifo_rd_ptr_empty #(.ADDR_WIDTH(4), .ALMOST_EMPTY_TH(2)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rd_en        (rd_en),
        .i_wptr_sync    (wptr),
        .o_rd_addr      (rd_addr),
        .o_rptr_gray    (rptr_gray),
        .o_empty        (empty),
        .o_almost_empty (aempty),
        .o_rd_count     (rd_count),
        .o_rd_ack       (rd_ack),
        .o_underflow    (uflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict the registered outputs, then compare after the edge.
    task automatic step(input logic rd, input logic [4:0] wg);
        exp_t e, o;
        logic [4:0] nb, wb;
        @(negedge clk);
        rd_en = rd;
        wptr  = wg;
        nb = m_rbin + {4'b0, rd & ~m_empty};
        wb = g2b(wg);
        e.addr   = nb[3:0];
        e.gray   = b2g(nb);
        e.empty  = (nb == wb);
        e.count  = wb - nb;
        e.aempty = (e.count <= 5'd2);
        e.ack    = rd & ~m_empty;
        e.uf     = rd & m_empty;
        sb_q.push_back(e);
        m_rbin  = nb;
        m_empty = e.empty;
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        chk("addr",   32'(rd_addr),   32'(o.addr));
        chk("gray",   32'(rptr_gray), 32'(o.gray));
        chk("empty",  32'(empty),     32'(o.empty));
        chk("aempty", 32'(aempty),    32'(o.aempty));
        chk("count",  32'(rd_count),  32'(o.count));
        chk("ack",    32'(rd_ack),    32'(o.ack));
        chk("uflow",  32'(uflow),     32'(o.uf));
        chk("cnt_bound", 32'(rd_count <= 5'd16), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"},  32'(empty),     32'd1);
        chk({tag, "_aempty"}, 32'(aempty),    32'd1);
        chk({tag, "_count"},  32'(rd_count),  32'd0);
        chk({tag, "_gray"},   32'(rptr_gray), 32'd0);
        chk({tag, "_addr"},   32'(rd_addr),   32'd0);
        chk({tag, "_ack"},    32'(rd_ack),    32'd0);
        chk({tag, "_uflow"},  32'(uflow),     32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd_en = 1'b0;
        wptr  = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_rbin  = '0;
        m_empty = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_addr;
        m_rbin  = '0;
        m_empty = 1'b1;

        // Reset held while the read request toggles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_en = ~rd_en;
            @(posedge clk);
            #1;
            chk_reset_vals("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b0;

        // Full then drain.
        step(1'b0, 5'b11000);
        chk("full_count", 32'(rd_count), 32'd16);
        chk("full_aempty", 32'(aempty), 32'd0);
        for (int i = 0; i < 14; i++) step(1'b1, 5'b11000);
        chk("drain14_count", 32'(rd_count), 32'd2);
        chk("drain14_aempty", 32'(aempty), 32'd1);
        step(1'b1, 5'b11000);
        step(1'b1, 5'b11000);
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_gray", 32'(rptr_gray), 32'b11000);

        // Single entry.
        do_reset();
        step(1'b0, 5'b00001);
        chk("single_empty", 32'(empty), 32'd0);
        chk("single_count", 32'(rd_count), 32'd1);
        step(1'b1, 5'b00001);
        chk("single_ack", 32'(rd_ack), 32'd1);
        chk("single_addr", 32'(rd_addr), 32'd1);
        chk("single_gray", 32'(rptr_gray), 32'b00001);
        chk("single_empty_after", 32'(empty), 32'd1);

        // Underflow: reads while empty are ignored.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'b00001);
            chk("uf_pulse", 32'(uflow), 32'd1);
            chk("uf_noack", 32'(rd_ack), 32'd0);
            chk("uf_addr", 32'(rd_addr), 32'd1);
        end

        // Wrap-around streaming with the write pointer three ahead.
        step(1'b0, b2g(5'(m_rbin + 5'd3)));
        exp_addr = m_rbin[3:0];
        for (int i = 0; i < 40; i++) begin
            step(1'b1, b2g(5'(m_rbin + 5'd4)));
            exp_addr = exp_addr + 4'd1;
            chk("wrap_count", 32'(rd_count), 32'd3);
            chk("wrap_addr", 32'(rd_addr), 32'(exp_addr));
        end

        // Same-cycle read of the last entry and a newly visible write.
        step(1'b0, b2g(5'(m_rbin + 5'd1)));
        step(1'b1, b2g(5'(m_rbin + 5'd2)));
        chk("simul_empty", 32'(empty), 32'd0);
        chk("simul_count", 32'(rd_count), 32'd1);

        // Asynchronous reset in the middle of activity.
        step(1'b0, b2g(5'(m_rbin + 5'd5)));
        step(1'b1, b2g(5'(m_rbin + 5'd6)));
        chk("mid_count", 32'(rd_count), 32'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rd_en = 1'b0;
        wptr  = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_rbin  = '0;
        m_empty = 1'b1;
        step(1'b0, 5'b00000);
        step(1'b1, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ptr_empty.md
Name: fifo_rd_ptr_empty

Overview:
Read-side pointer and status controller of the asynchronous FIFO, running entirely in the read clock domain. It consumes the write pointer (Gray code) after it has been brought across by the two-flop synchronizer stage. It maintains the binary and Gray read pointers and drives the RAM read address. It produces registered empty, almost-empty and fill-level status, and exports its Gray pointer for synchronization back into the write domain.

Parameters:
ADDR_WIDTH, 4, FIFO address bits; depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
ALMOST_EMPTY_TH, 2, o_almost_empty asserts when fill level <= this value; legal range 0..DEPTH-1.

Ports:
i_clk  input  1  read-domain clock; one clock only.
i_rst_n  input  1  asynchronous active-low reset.
i_rd_en  input  1  read request from the consumer.
i_wptr_sync  input  ADDR_WIDTH+1  write pointer in Gray code, already synchronized into i_clk.
o_rd_addr  output  ADDR_WIDTH  RAM read address, equal to the binary read pointer LSBs.
o_rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
o_empty  output  1  FIFO empty, registered.
o_almost_empty  output  1  fill level <= ALMOST_EMPTY_TH, registered.
o_rd_count  output  ADDR_WIDTH+1  fill level as seen by the read side, 0..DEPTH, registered.
o_rd_ack  output  1  one-cycle pulse: the read in the previous cycle was accepted.
o_underflow  output  1  one-cycle pulse: the previous cycle had i_rd_en=1 while o_empty=1.

Behaviour:
- Reset (async assert, sync deassert by the system) sets all state and outputs to known values.
  - rbin=0, o_rptr_gray=0, o_rd_addr=0.
  - o_empty=1, o_almost_empty=1, o_rd_count=0.
  - o_rd_ack=0, o_underflow=0.
- Read accept: rinc = i_rd_en & ~o_empty. Only accepted reads advance the pointer. A read while empty is ignored and flagged on o_underflow.
- Next-state arithmetic:
  - rbin_next = rbin + rinc, modulo 2**(ADDR_WIDTH+1); the pointer wraps naturally with no special-case logic.
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
- All status flags are computed from next-state values and registered, so each updates in the same edge as the pointer.
  - o_empty <= (rgray_next == i_wptr_sync), a full-width compare including the MSB.
  - wbin = Gray-to-binary of i_wptr_sync.
  - o_rd_count <= wbin - rbin_next, modulo 2**(ADDR_WIDTH+1).
  - o_almost_empty <= (wbin - rbin_next) <= ALMOST_EMPTY_TH.
- Read data timing: o_rd_addr is driven directly from the rbin register. The RAM presents data for the current head entry; an accepted read in cycle N moves the address in cycle N+1.
- Write visibility latency:
  - A write appears here 2 read clocks after the write-domain Gray pointer changes (synchronizer stage), plus 1 clock for this block's registers.
  - Empty deassertion is therefore pessimistic (late), never early. Empty assertion after the last read is immediate (next edge).
- Simultaneous events:
  - Read of the last entry while the synced pointer advances in the same cycle: the flags use the new i_wptr_sync, so o_empty stays 0 and o_rd_count reflects both events.
- Wrap-around:
  - Empty is equality of full (ADDR_WIDTH+1)-bit Gray pointers.
  - Pointers equal in the LSBs but differing in the MSB mean DEPTH entries: o_rd_count=DEPTH, o_empty=0.
- Count bound: under legal operation o_rd_count <= DEPTH always. The block does not clamp; the bench asserts the bound.
- Reset mid-operation: all outputs return to their reset values asynchronously. A simultaneous write-side reset is the system's responsibility.

Decomposition:
- Shared FIFO header/package holds:
  - ADDR_WIDTH default, DEPTH and PTR_WIDTH derived constants.
  - The bin2gray and gray2bin functions, reused by the write-side full-flag block.
- One sub-module is natural: gray_to_bin, purely combinational and parameterized on width; it is instanced once for wbin.
- The synchronizer stage stays external; this block does not instance it.

Test Plan:
- Reset check: hold i_rst_n=0, toggle i_rd_en -> o_empty=1, o_almost_empty=1, o_rd_count=0, o_rptr_gray=0, no ack pulses.
- Single entry: i_wptr_sync steps Gray 0->1 -> next edge o_empty=0, o_rd_count=1, o_almost_empty=1. One read -> o_rd_ack pulse, o_rd_addr=1, o_rptr_gray=00001, o_empty=1 on the same edge.
- Full then drain (ADDR_WIDTH=4): i_wptr_sync = Gray(16) = 11000 -> o_rd_count=16, o_almost_empty=0. 14 reads -> o_almost_empty rises when the count reaches 2. 16 reads -> o_empty=1, o_rptr_gray=11000.
- Underflow: i_rd_en=1 while empty for 3 cycles -> o_underflow=1 for 3 cycles, rbin unchanged, o_rd_ack=0.
- Wrap-around: stream 40 writes/reads, with i_wptr_sync leading rbin by 3 -> pointer passes 31->0 cleanly, o_rd_count stays 3, o_rd_addr sequence is 0..15 repeating.
- Reset mid-operation: with o_rd_count=5 and reads in flight, pulse i_rst_n low between edges -> all outputs go to reset values immediately, without waiting for a clock edge.
